// File: rtl/tests_pkg.sv
// Shared types and defaults for the random-stall test slice.
//   tests_stall_stat_t      : statistics snapshot {stall_cnt, xfer_cnt}
//   TESTS_CNT_WIDTH_DEFAULT : default width of the statistics counters
package tests_pkg;

    localparam int unsigned TESTS_CNT_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic [TESTS_CNT_WIDTH_DEFAULT-1:0] stall_cnt;
        logic [TESTS_CNT_WIDTH_DEFAULT-1:0] xfer_cnt;
    } tests_stall_stat_t;

endpackage

// File: rtl/tests_sync_fifo.sv
// Synchronous FIFO with registered occupancy and full/empty flags. No bypass:
// a written entry becomes visible at the head one cycle later.
//   clk, rst     : clock, synchronous active-high reset (control state only)
//   push_i       : write wdata_i at the tail (caller guarantees !full_o)
//   pop_i        : drop the head entry (caller guarantees !empty_o)
//   rdata_o      : current head entry
//   occupancy_o  : number of valid entries
//   full_o       : occupancy == DEPTH
//   empty_o      : occupancy == 0
module tests_sync_fifo
    import tests_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]       occ_q, occ_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == OccW'(DEPTH));
    assign empty_o     = (occ_q == '0);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));
    a_occ_bound:    assert property (@(posedge clk) disable iff (rst) occ_q <= OccW'(DEPTH));

endmodule

// File: rtl/tests_stall_slice.sv
// Test-only valid/ready slice that injects bubbles on the downstream side when
// stall_i is asserted, buffering beats in a small FIFO. Exports stall/transfer stats.
//   clk, rst      : clock, synchronous active-high reset
//   stall_i       : bubble request from the random-stall generator
//   s_valid_i/s_ready_o/s_data_i : upstream channel
//   m_valid_o/m_ready_i/m_data_o : downstream channel (m_data_o is the FIFO head)
//   occupancy_o   : valid entries held
//   stall_cnt_o   : injected bubble cycles, saturating
//   xfer_cnt_o    : downstream handshakes, wrapping
module tests_stall_slice
    import tests_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = TESTS_CNT_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [DATA_WIDTH-1:0]  s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DATA_WIDTH-1:0]  m_data_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [CNT_WIDTH-1:0]   stall_cnt_o,
    output logic [CNT_WIDTH-1:0]   xfer_cnt_o
);

    logic                 full, empty, push, pop, bubble;
    logic                 hold_q, hold_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

    tests_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .wdata_i     (s_data_i),
        .rdata_o     (m_data_o),
        .occupancy_o (occupancy_o),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        // A full FIFO refuses a push even if a pop happens in the same cycle.
        s_ready_o = !full && !rst;
        // Once offered, valid is held until accepted; a late stall cannot retract it.
        m_valid_o = !empty && (!stall_i || hold_q) && !rst;
        push      = s_valid_i && s_ready_o;
        pop       = m_valid_o && m_ready_i;
        bubble    = !empty && stall_i && !hold_q;

        hold_d = hold_q;
        if (pop)                          hold_d = 1'b0;
        else if (m_valid_o && !m_ready_i) hold_d = 1'b1;

        stall_cnt_d = stall_cnt_q;
        if (bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);

        xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= 1'b0;
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign xfer_cnt_o  = xfer_cnt_q;

    a_offer_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o)));

endmodule

// File: tb/tb_tests_stall_slice.sv
module tb_tests_stall_slice;
    import tests_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 4;
    localparam int unsigned OW    = $clog2(DEPTH) + 1;
    localparam logic [TESTS_CNT_WIDTH_DEFAULT-1:0] CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, stall_i, s_valid_i, s_ready_o, m_valid_o, m_ready_i;
    logic [DW-1:0] s_data_i, m_data_o;
    logic [OW-1:0] occupancy_o;
    logic [CW-1:0] stall_cnt_o, xfer_cnt_o;

    always #5 clk = ~clk;

    tests_stall_slice #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o),
        .xfer_cnt_o  (xfer_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of buffered beats, an "offer pending" flag and stats.
    logic [DW-1:0]     mq[$];
    logic              offered = 1'b0;
    tests_stall_stat_t stat = '0;

    logic          exp_s_ready, exp_m_valid;
    logic [DW-1:0] exp_m_data;
    logic [OW-1:0] exp_occ;

    // Apply inputs just after a rising edge, then settle to the falling edge and
    // compute the expected outputs for this cycle.
    task automatic drive(input logic r, input logic st, input logic sv,
                         input logic [DW-1:0] sd, input logic mr);
        rst = r; stall_i = st; s_valid_i = sv; s_data_i = sd; m_ready_i = mr;
        @(negedge clk);
        exp_s_ready = !r && (mq.size() < DEPTH);
        exp_m_valid = !r && (mq.size() > 0) && (!st || offered);
        exp_m_data  = (mq.size() > 0) ? mq[0] : '0;
        exp_occ     = OW'(mq.size());
    endtask

    // Commit the model for the current cycle and move past the next rising edge.
    task automatic advance();
        logic push, pop;
        push = s_valid_i && exp_s_ready;
        pop  = exp_m_valid && m_ready_i;
        if (rst) begin
            mq.delete();
            offered = 1'b0;
            stat    = '0;
        end else begin
            if ((mq.size() > 0) && stall_i && !offered)
                stat.stall_cnt = (stat.stall_cnt == CNT_MAX) ? CNT_MAX : stat.stall_cnt + 1;
            if (pop) stat.xfer_cnt = (stat.xfer_cnt + 1) & CNT_MAX;
            if (pop) begin
                void'(mq.pop_front());
                offered = 1'b0;
            end else if (exp_m_valid && !m_ready_i) begin
                offered = 1'b1;
            end
            if (push) mq.push_back(s_data_i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid_o); end
        total++; if (s_ready_o !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready_o); end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        total++; if (s_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_s_ready got=%b want=1", s_ready_o); end
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL post_reset_m_valid got=%b want=0", m_valid_o); end
        total++; if (occupancy_o !== '0) begin bad++; $display("FAIL post_reset_occ got=%0d want=0", occupancy_o); end
        total++; if (stall_cnt_o !== '0 || xfer_cnt_o !== '0) begin
            bad++; $display("FAIL post_reset_cnt got=%0d/%0d want=0/0", stall_cnt_o, xfer_cnt_o);
        end
        advance();
    endtask

    task automatic test_pass_through();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, DW'(32'hA + i), 1'b1);
            total++; if (s_ready_o !== 1'b1) begin bad++; $display("FAIL pt_s_ready[%0d] got=%b want=1", i, s_ready_o); end
            if (i > 0) begin
                total++; if (m_valid_o !== 1'b1 || m_data_o !== DW'(32'hA + i - 1)) begin
                    bad++; $display("FAIL pt_out[%0d] got=%b/%h want=1/%h", i, m_valid_o, m_data_o, 32'hA + i - 1);
                end
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (m_valid_o !== 1'b1 || m_data_o !== 32'hC) begin
            bad++; $display("FAIL pt_last got=%b/%h want=1/c", m_valid_o, m_data_o);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (xfer_cnt_o !== 4'd3 || stall_cnt_o !== 4'd0 || m_valid_o !== 1'b0) begin
            bad++; $display("FAIL pt_stats got=x%0d s%0d v%b want=x3 s0 v0", xfer_cnt_o, stall_cnt_o, m_valid_o);
        end
        advance();
    endtask

    task automatic test_stall_bubble();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 32'h55, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
            total++; if (m_valid_o !== 1'b0 || occupancy_o !== OW'(1)) begin
                bad++; $display("FAIL bubble_v[%0d] got=%b occ=%0d want=0 occ=1", i, m_valid_o, occupancy_o);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h55 || stall_cnt_o !== 4'd4) begin
            bad++; $display("FAIL bubble_release got=%b/%h s%0d want=1/55 s4", m_valid_o, m_data_o, stall_cnt_o);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (occupancy_o !== '0 || xfer_cnt_o !== 4'd1) begin
            bad++; $display("FAIL bubble_after got=occ%0d x%0d want=occ0 x1", occupancy_o, xfer_cnt_o);
        end
        advance();
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        total++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h77) begin
            bad++; $display("FAIL hold_offer got=%b/%h want=1/77", m_valid_o, m_data_o);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
            total++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h77 || stall_cnt_o !== 4'd0) begin
                bad++; $display("FAIL hold_stall[%0d] got=%b/%h s%0d want=1/77 s0", i, m_valid_o, m_data_o, stall_cnt_o);
            end
            advance();
        end
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        total++; if (m_valid_o !== 1'b1) begin bad++; $display("FAIL hold_accept got=%b want=1", m_valid_o); end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (occupancy_o !== '0 || xfer_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin
            bad++; $display("FAIL hold_after got=occ%0d x%0d s%0d want=0 1 0", occupancy_o, xfer_cnt_o, stall_cnt_o);
        end
        advance();
    endtask

    task automatic test_full();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h1, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
        total++; if (s_ready_o !== 1'b1) begin bad++; $display("FAIL full_second got=%b want=1", s_ready_o); end
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h3, 1'b0);
            total++; if (s_ready_o !== 1'b0 || occupancy_o !== OW'(2)) begin
                bad++; $display("FAIL full_block[%0d] got=r%b occ%0d want=r0 occ2", i, s_ready_o, occupancy_o);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b1, 32'h3, 1'b1);
        total++; if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1 || m_data_o !== 32'h1) begin
            bad++; $display("FAIL full_pop got=r%b v%b d%h want=r0 v1 d1", s_ready_o, m_valid_o, m_data_o);
        end
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h3, 1'b1);
        total++; if (s_ready_o !== 1'b1 || occupancy_o !== OW'(1) || m_data_o !== 32'h2) begin
            bad++; $display("FAIL full_refill got=r%b occ%0d d%h want=r1 occ1 d2", s_ready_o, occupancy_o, m_data_o);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (m_data_o !== 32'h3 || occupancy_o !== OW'(1)) begin
            bad++; $display("FAIL full_third got=d%h occ%0d want=d3 occ1", m_data_o, occupancy_o);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (xfer_cnt_o !== 4'd3 || occupancy_o !== '0) begin
            bad++; $display("FAIL full_stats got=x%0d occ%0d want=x3 occ0", xfer_cnt_o, occupancy_o);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'hA1, 1'b0); advance();
        drive(1'b0, 1'b1, 1'b1, 32'hA2, 1'b0); advance();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);     advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        total++; if (occupancy_o !== OW'(2) || stall_cnt_o !== 4'd2) begin
            bad++; $display("FAIL mid_pre got=occ%0d s%0d want=occ2 s2", occupancy_o, stall_cnt_o);
        end
        advance();
        drive(1'b1, 1'b0, 1'b1, 32'h99, 1'b1);
        total++; if (m_valid_o !== 1'b0 || s_ready_o !== 1'b0) begin
            bad++; $display("FAIL mid_during got=v%b r%b want=v0 r0", m_valid_o, s_ready_o);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0 || occupancy_o !== '0 ||
                     stall_cnt_o !== '0 || xfer_cnt_o !== '0) begin
            bad++; $display("FAIL mid_after got=r%b v%b occ%0d s%0d x%0d want=1 0 0 0 0",
                            s_ready_o, m_valid_o, occupancy_o, stall_cnt_o, xfer_cnt_o);
        end
        advance();
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1); advance();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
            advance();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, DW'(32'h200 + i), 1'b1);
            total++; if (m_valid_o !== exp_m_valid || m_data_o !== exp_m_data) begin
                bad++; $display("FAIL sat_stream[%0d] got=%b/%h want=%b/%h", i, m_valid_o, m_data_o, exp_m_valid, exp_m_data);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1); advance();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        total++; if (stall_cnt_o !== 4'hF || xfer_cnt_o !== 4'd1 || occupancy_o !== '0) begin
            bad++; $display("FAIL sat_stats got=s%h x%0d occ%0d want=sf x1 occ0", stall_cnt_o, xfer_cnt_o, occupancy_o);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 99) < 65);
            total++; if (s_ready_o !== exp_s_ready) begin
                bad++; $display("FAIL rnd_s_ready[%0d] got=%b want=%b", i, s_ready_o, exp_s_ready);
            end
            total++; if (m_valid_o !== exp_m_valid) begin
                bad++; $display("FAIL rnd_m_valid[%0d] got=%b want=%b", i, m_valid_o, exp_m_valid);
            end
            if (exp_m_valid) begin
                total++; if (m_data_o !== exp_m_data) begin
                    bad++; $display("FAIL rnd_m_data[%0d] got=%h want=%h", i, m_data_o, exp_m_data);
                end
            end
            total++; if (occupancy_o !== exp_occ) begin
                bad++; $display("FAIL rnd_occ[%0d] got=%0d want=%0d", i, occupancy_o, exp_occ);
            end
            total++; if (stall_cnt_o !== stat.stall_cnt[CW-1:0] || xfer_cnt_o !== stat.xfer_cnt[CW-1:0]) begin
                bad++; $display("FAIL rnd_cnt[%0d] got=s%0d x%0d want=s%0d x%0d", i, stall_cnt_o, xfer_cnt_o,
                                stat.stall_cnt[CW-1:0], stat.xfer_cnt[CW-1:0]);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall_bubble();
        test_hold();
        test_full();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
